// File: rtl/ws2812_tx.sv
// ws2812_tx: serialises 24-bit GRB pixel words from a pixel buffer onto a WS2812
// LED chain. After the last bit it holds the line low for a latch gap, then
// pulses done.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       one-cycle frame request, accepted only from idle
//   num_leds    LED count for the frame, captured at start
//   rd_addr     pixel buffer read address (11 bits, LED index truncated)
//   rd_data     pixel word {G,R,B}, valid one cycle after rd_addr
//   brightness  per-channel scale (only when WS2812_TX_BRIGHT_EN is defined)
//   dout        serial line to the LED chain
//   busy        high while a frame or latch gap is in progress
//   done        one-cycle pulse at frame completion
//
// Optional feature macro: WS2812_TX_BRIGHT_EN adds the brightness input and
// scales each channel as (c*(brightness+1))>>8 when a word is loaded.
module ws2812_tx #(
    parameter int unsigned T0H_CYC   = 20,
    parameter int unsigned T1H_CYC   = 40,
    parameter int unsigned BIT_CYC   = 62,
    parameter int unsigned LATCH_CYC = 3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] num_leds,
    output logic [10:0] rd_addr,
    input  logic [23:0] rd_data,
`ifdef WS2812_TX_BRIGHT_EN
    input  logic [7:0]  brightness,
`endif
    output logic        dout,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CW = $clog2(BIT_CYC + 1);
    localparam int unsigned LW = $clog2(LATCH_CYC + 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StHigh,
        StLow,
        StLatch
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] count_q, count_d;
    logic [11:0] led_q, led_d;
    logic [23:0] shift_q, shift_d;
    logic [4:0]  bit_q, bit_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [10:0] addr_q, addr_d;
    logic        dout_q, dout_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [23:0] load_word;
    logic [11:0] next_led;
    logic        last_led;
    logic [CW-1:0] high_last;

`ifdef WS2812_TX_BRIGHT_EN
    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = {8'd0, c} * ({8'd0, b} + 16'd1);
        return p[15:8];
    endfunction

    assign load_word = {scale_ch(rd_data[23:16], brightness),
                        scale_ch(rd_data[15:8], brightness),
                        scale_ch(rd_data[7:0], brightness)};
`else
    assign load_word = rd_data;
`endif

    assign next_led  = led_q + 12'd1;
    // Current LED is the final one when index+1 reaches the captured count.
    assign last_led  = ({1'b0, next_led} >= {1'b0, count_q});
    assign high_last = shift_q[23] ? CW'(T1H_CYC - 1) : CW'(T0H_CYC - 1);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        led_d   = led_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        cyc_d   = cyc_q;
        lat_d   = lat_q;
        addr_d  = addr_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                // done_q high means the previous frame just ended this cycle.
                if (start && !done_q) begin
                    count_d = num_leds;
                    led_d   = 12'd0;
                    addr_d  = 11'd0;
                    lat_d   = '0;
                    state_d = (num_leds == 12'd0) ? StLatch : StFetch;
                end
            end
            StFetch: state_d = StLoad;
            StLoad: begin
                shift_d = load_word;
                bit_d   = 5'd23;
                cyc_d   = '0;
                state_d = StHigh;
            end
            StHigh: begin
                // Prefetch the next LED word at the start of bit 0.
                if (bit_q == 5'd0 && cyc_q == '0 && !last_led) begin
                    addr_d = next_led[10:0];
                end
                if (cyc_q == high_last) begin
                    state_d = StLow;
                end
                cyc_d = cyc_q + 1'b1;
            end
            StLow: begin
                if (cyc_q == CW'(BIT_CYC - 1)) begin
                    cyc_d = '0;
                    if (bit_q == 5'd0) begin
                        if (last_led) begin
                            lat_d   = '0;
                            state_d = StLatch;
                        end else begin
                            led_d   = next_led;
                            shift_d = load_word;
                            bit_d   = 5'd23;
                            state_d = StHigh;
                        end
                    end else begin
                        bit_d   = bit_q - 5'd1;
                        shift_d = {shift_q[22:0], 1'b0};
                        state_d = StHigh;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StLatch: begin
                if (lat_q == LW'(LATCH_CYC - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        dout_d = (state_d == StHigh);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            led_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            cyc_q   <= '0;
            lat_q   <= '0;
            addr_q  <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            led_q   <= led_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            cyc_q   <= cyc_d;
            lat_q   <= lat_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rd_addr = addr_q;
    assign dout    = dout_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_ws2812_tx.sv
// Testbench for ws2812_tx: builds the expected dout waveform of each frame from
// the pixel words and the bit timing rules, then compares cycle by cycle.
module tb_ws2812_tx;

    localparam int T0H   = 20;
    localparam int T1H   = 40;
    localparam int BITC  = 62;
    localparam int LATCH = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] num_leds = 12'd0;
    logic [10:0] rd_addr;
    logic [23:0] rd_data;
    logic        dout, busy, done;
`ifdef WS2812_TX_BRIGHT_EN
    logic [7:0]  brightness = 8'd255;
`endif

    logic [23:0] mem [0:2047];
    bit          exp_q [$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    ws2812_tx #(
        .T0H_CYC  (T0H),
        .T1H_CYC  (T1H),
        .BIT_CYC  (BITC),
        .LATCH_CYC(LATCH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .num_leds(num_leds),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
`ifdef WS2812_TX_BRIGHT_EN
        .brightness(brightness),
`endif
        .dout    (dout),
        .busy    (busy),
        .done    (done)
    );

    // Colour word the LEDs should receive for a stored word.
    function automatic logic [23:0] expect_word(input logic [23:0] w);
`ifdef WS2812_TX_BRIGHT_EN
        logic [23:0] r;
        for (int c = 0; c < 3; c++) begin
            int v;
            v = (int'(w[8*c +: 8]) * (int'(brightness) + 1)) / 256;
            r[8*c +: 8] = v[7:0];
        end
        return r;
`else
        return w;
`endif
    endfunction

    // Expected dout per cycle after the start edge, up to the end of the latch gap.
    task automatic build_expect(input int n);
        exp_q.delete();
        if (n > 0) begin
            exp_q.push_back(1'b0);
            exp_q.push_back(1'b0);
        end
        for (int i = 0; i < n; i++) begin
            logic [23:0] w;
            w = expect_word(mem[i % 2048]);
            for (int b = 23; b >= 0; b--) begin
                int th;
                th = w[b] ? T1H : T0H;
                for (int c = 0; c < BITC; c++) exp_q.push_back(c < th);
            end
        end
        for (int c = 0; c < LATCH; c++) exp_q.push_back(1'b0);
    endtask

    // Runs one frame from idle; optionally pokes start mid-frame and at done.
    task automatic run_frame(input string name, input int n, input bit poke_busy,
                             input bit poke_done);
        logic [10:0] addr_seq [$];
        bit bad;
        int len;
        build_expect(n);
        len = exp_q.size();
        bad = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        num_leds = 12'(n);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < len; k++) begin
            if (k == 0 || rd_addr != addr_seq[addr_seq.size()-1]) addr_seq.push_back(rd_addr);
            if (!bad && (dout !== exp_q[k] || busy !== 1'b1 || done !== 1'b0)) begin
                $display("FAIL %s wave cycle %0d: dout=%b busy=%b done=%b, want dout=%b busy=1 done=0",
                         name, k, dout, busy, done, exp_q[k]);
                bad = 1'b1;
            end
            if (poke_busy && k == len / 2) begin
                start = 1'b1;
                num_leds = 12'($urandom_range(1, 4095));
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (bad) miscompares++;

        vectors++;
        if (addr_seq.size() != ((n > 0) ? n : 1)) begin
            $display("FAIL %s addr count: got %0d, want %0d", name, addr_seq.size(),
                     (n > 0) ? n : 1);
            miscompares++;
        end else begin
            for (int j = 0; j < addr_seq.size(); j++) begin
                if (addr_seq[j] !== 11'(j)) begin
                    $display("FAIL %s addr step %0d: got %0d, want %0d", name, j,
                             addr_seq[j], j);
                    miscompares++;
                    break;
                end
            end
        end

        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || dout !== 1'b0) begin
            $display("FAIL %s done pulse: done=%b busy=%b dout=%b, want 1 0 0",
                     name, done, busy, dout);
            miscompares++;
        end
        if (poke_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (done !== 1'b0 || busy !== 1'b0 || dout !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        if (bad) begin
            $display("FAIL %s after done: done=%b busy=%b dout=%b, want 0 0 0",
                     name, done, busy, dout);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_addr !== 11'd0) begin
            $display("FAIL reset: dout=%b busy=%b done=%b rd_addr=%0d, want 0 0 0 0",
                     dout, busy, done, rd_addr);
            miscompares++;
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL idle after reset: dout=%b busy=%b done=%b, want 0 0 0",
                     dout, busy, done);
            miscompares++;
        end
    endtask

    task automatic test_single();
        mem[0] = 24'hFF0000;
        run_frame("single", 1, 1'b0, 1'b0);
    endtask

    task automatic test_three();
        mem[0] = 24'h000001;
        mem[1] = 24'h800000;
        mem[2] = 24'h0000FF;
        run_frame("three", 3, 1'b0, 1'b0);
    endtask

    task automatic test_zero();
        run_frame("zero", 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            int n;
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) mem[i] = 24'($urandom);
`ifdef WS2812_TX_BRIGHT_EN
            brightness = 8'($urandom);
`endif
            run_frame("random", n, 1'b0, 1'b0);
        end
`ifdef WS2812_TX_BRIGHT_EN
        brightness = 8'd255;
`endif
    endtask

    task automatic test_ignored_starts();
        mem[0] = 24'h5A3C96;
        mem[1] = 24'hA5C369;
        run_frame("ignored_starts", 2, 1'b1, 1'b1);
    endtask

    task automatic test_midbit_reset();
        mem[0] = 24'hFFFFFF;
        @(posedge clk); #1;
        start = 1'b1;
        num_leds = 12'd1;
        @(posedge clk); #1;
        start = 1'b0;
        // Two setup cycles, then ten full bits, then partway into bit 10.
        repeat (2 + 10 * BITC + 5) @(posedge clk);
        #1;
        vectors++;
        if (dout !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL midbit pre-reset: dout=%b busy=%b, want 1 1", dout, busy);
            miscompares++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_addr !== 11'd0) begin
            $display("FAIL midbit reset: dout=%b busy=%b done=%b rd_addr=%0d, want 0 0 0 0",
                     dout, busy, done, rd_addr);
            miscompares++;
        end
        mem[0] = 24'h13579B;
        run_frame("after_reset", 1, 1'b0, 1'b0);
    endtask

`ifdef WS2812_TX_BRIGHT_EN
    task automatic test_bright();
        brightness = 8'd127;
        mem[0] = 24'hFF8001;
        run_frame("bright", 1, 1'b0, 1'b0);
        brightness = 8'd255;
    endtask
`endif

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 24'd0;
        test_reset();
        test_single();
        test_three();
        test_zero();
        test_random();
        test_ignored_starts();
        test_midbit_reset();
`ifdef WS2812_TX_BRIGHT_EN
        test_bright();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
